// File: rtl/spi_axi_burst_splitter.sv
// Read-only AXI4 burst splitter between the host read path and the quad-SPI
// XIP flash read port. Long INCR bursts are cut into device sub-bursts of at
// most MaxBeats beats. Read data is stitched back into one host burst that
// carries a single rlast. Only one transaction is in flight at a time.
module spi_axi_burst_splitter #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 24,
  parameter int IdWidth   = 1,
  parameter int MaxBeats  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // host AR
  input  logic                 s_ar_valid,
  output logic                 s_ar_ready,
  input  logic [AddrWidth-1:0] s_ar_addr,
  input  logic [IdWidth-1:0]   s_ar_id,
  input  logic [7:0]           s_ar_len,
  input  logic [2:0]           s_ar_size,
  input  logic [1:0]           s_ar_burst,
  // host R
  output logic                 s_r_valid,
  input  logic                 s_r_ready,
  output logic [DataWidth-1:0] s_r_data,
  output logic [IdWidth-1:0]   s_r_id,
  output logic [1:0]           s_r_resp,
  output logic                 s_r_last,
  // device AR
  output logic                 m_ar_valid,
  input  logic                 m_ar_ready,
  output logic [AddrWidth-1:0] m_ar_addr,
  output logic [IdWidth-1:0]   m_ar_id,
  output logic [7:0]           m_ar_len,
  output logic [2:0]           m_ar_size,
  output logic [1:0]           m_ar_burst,
  // device R
  input  logic                 m_r_valid,
  output logic                 m_r_ready,
  input  logic [DataWidth-1:0] m_r_data,
  input  logic [IdWidth-1:0]   m_r_id,
  input  logic [1:0]           m_r_resp,
  input  logic                 m_r_last
);

  localparam logic [1:0] BurstIncr = 2'b01;
  localparam logic [8:0] MaxChunk  = 9'(MaxBeats);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DATA
  } state_e;

  state_e               r_state;
  state_e               w_next_state;

  // Latched host request; r_rem counts beats still owed to the host (1..256).
  logic [AddrWidth-1:0] r_addr;
  logic [IdWidth-1:0]   r_id;
  logic [2:0]           r_size;
  logic [1:0]           r_burst;
  logic [8:0]           r_rem;

  logic [8:0]           w_chunk;
  logic                 w_final_chunk;
  logic [AddrWidth-1:0] w_step;
  logic                 w_host_accept;
  logic                 w_sub_done;
  logic                 w_unused_rid;

  // Only INCR is split; FIXED/WRAP are at most 16 beats and go out whole.
  assign w_chunk       = (r_burst == BurstIncr && r_rem > MaxChunk) ? MaxChunk : r_rem;
  assign w_final_chunk = (r_rem == w_chunk);
  assign w_step        = AddrWidth'(w_chunk) << r_size;

  assign w_host_accept = (r_state == S_IDLE) && s_ar_valid && !rst_i;
  assign w_sub_done    = (r_state == S_DATA) && m_r_valid && s_r_ready && m_r_last;

  // Device AR payload comes straight from the latched registers.
  assign m_ar_addr  = r_addr;
  assign m_ar_id    = r_id;
  assign m_ar_len   = 8'(w_chunk - 9'd1);
  assign m_ar_size  = r_size;
  assign m_ar_burst = r_burst;

  // Device ID is meaningless here: the host always sees its own ID back.
  assign s_r_data     = m_r_data;
  assign s_r_resp     = m_r_resp;
  assign s_r_id       = r_id;
  assign w_unused_rid = ^m_r_id;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs; R path is a pure pass-through in DATA.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    w_next_state = r_state;
    s_ar_ready   = 1'b0;
    m_ar_valid   = 1'b0;
    s_r_valid    = 1'b0;
    m_r_ready    = 1'b0;
    s_r_last     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        s_ar_ready = !rst_i;
        if (w_host_accept) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        m_ar_valid = 1'b1;
        if (m_ar_ready) w_next_state = S_DATA;
      end
      S_DATA: begin
        s_r_valid = m_r_valid;
        m_r_ready = s_r_ready;
        // Sub-burst lasts are hidden; only the final chunk's last reaches the host.
        s_r_last  = m_r_last && w_final_chunk;
        if (w_sub_done) w_next_state = w_final_chunk ? S_IDLE : S_ISSUE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Latch the host request, then advance address/remaining count per sub-burst.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: every latched field is cleared so no stale payload survives an aborted transaction.
      r_addr  <= '0;
      r_id    <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_rem   <= '0;
    end else if (w_host_accept) begin
      r_addr  <= s_ar_addr;
      r_id    <= s_ar_id;
      r_size  <= s_ar_size;
      r_burst <= s_ar_burst;
      r_rem   <= {1'b0, s_ar_len} + 9'd1;
    end else if (w_sub_done && !w_final_chunk) begin
      r_rem  <= r_rem - w_chunk;
      r_addr <= r_addr + w_step;
    end
  end

  // The device must stay quiet until a sub-burst has been issued.
  a_no_early_rdata: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_state != S_DATA) |-> !m_r_valid)
    else $error("device R valid outside DATA state");

endmodule

// File: tb/tb_spi_axi_burst_splitter.sv
// Self-checking bench for spi_axi_burst_splitter: directed scenarios plus
// randomized bursts, checked every cycle against a transaction-level model.
module tb_spi_axi_burst_splitter;

  localparam int DW = 32;
  localparam int AW = 24;
  localparam int IW = 1;
  localparam int MB = 16;

  logic          clk_i, rst_i;
  logic          s_ar_valid, s_ar_ready;
  logic [AW-1:0] s_ar_addr;
  logic [IW-1:0] s_ar_id;
  logic [7:0]    s_ar_len;
  logic [2:0]    s_ar_size;
  logic [1:0]    s_ar_burst;
  logic          s_r_valid, s_r_ready;
  logic [DW-1:0] s_r_data;
  logic [IW-1:0] s_r_id;
  logic [1:0]    s_r_resp;
  logic          s_r_last;
  logic          m_ar_valid, m_ar_ready;
  logic [AW-1:0] m_ar_addr;
  logic [IW-1:0] m_ar_id;
  logic [7:0]    m_ar_len;
  logic [2:0]    m_ar_size;
  logic [1:0]    m_ar_burst;
  logic          m_r_valid, m_r_ready;
  logic [DW-1:0] m_r_data;
  logic [IW-1:0] m_r_id;
  logic [1:0]    m_r_resp;
  logic          m_r_last;

  spi_axi_burst_splitter #(
    .DataWidth(DW), .AddrWidth(AW), .IdWidth(IW), .MaxBeats(MB)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_ar_id(s_ar_id), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
    .s_r_id(s_r_id), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_id(m_ar_id), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
    .m_r_id(m_r_id), .m_r_resp(m_r_resp), .m_r_last(m_r_last)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [IW-1:0] id;
    logic [2:0]    size;
    logic [1:0]    burst;
  } ar_t;

  ar_t           exp_ar_q[$];   // device ARs the model still expects
  ar_t           ar_log[$];     // device ARs seen in the current transaction
  int            n_vec, n_err;
  bit            txn_active, dev_busy, mr_hs_last;
  int            dev_left, host_idx, host_n, last_count;
  logic [IW-1:0] host_id;
  int            ready_mode;    // 0: always ready, 1: toggle, 2: random
  int            arready_pct;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: which device ARs one host AR must produce.
  function automatic void model_split(input ar_t h);
    int     rem;
    int     c;
    longint a;
    ar_t    s;
    rem = int'(h.len) + 1;
    a   = longint'(h.addr);
    if (h.burst == 2'd1) begin
      while (rem > 0) begin
        c      = (rem > MB) ? MB : rem;
        s      = h;
        s.addr = a[AW-1:0];
        s.len  = 8'(c - 1);
        exp_ar_q.push_back(s);
        a   = (a + longint'(c) * (longint'(1) << h.size)) % (longint'(1) << AW);
        rem = rem - c;
      end
    end else begin
      exp_ar_q.push_back(h);
    end
  endfunction

  task automatic flush_model();
    txn_active = 1'b0;
    dev_busy   = 1'b0;
    dev_left   = 0;
    mr_hs_last = 1'b0;
    host_idx   = 0;
    exp_ar_q.delete();
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  task automatic monitor_cycle();
    ar_t e;
    ar_t got;
    check("s_ar_ready", 64'(s_ar_ready), 64'(!txn_active));
    check("m_ar_valid", 64'(m_ar_valid), 64'(txn_active && exp_ar_q.size() > 0 && !dev_busy));
    if (dev_busy) check("m_r_ready_mirror", 64'(m_r_ready), 64'(s_r_ready));
    mr_hs_last = m_r_valid && m_r_ready;
    if (m_ar_valid && m_ar_ready) begin
      check("m_ar_expected", 64'(exp_ar_q.size() > 0), 64'd1);
      if (exp_ar_q.size() > 0) begin
        e = exp_ar_q.pop_front();
        check("m_ar_addr", 64'(m_ar_addr), 64'(e.addr));
        check("m_ar_len", 64'(m_ar_len), 64'(e.len));
        check("m_ar_id", 64'(m_ar_id), 64'(e.id));
        check("m_ar_size", 64'(m_ar_size), 64'(e.size));
        check("m_ar_burst", 64'(m_ar_burst), 64'(e.burst));
      end
      got.addr = m_ar_addr; got.len = m_ar_len; got.id = m_ar_id;
      got.size = m_ar_size; got.burst = m_ar_burst;
      ar_log.push_back(got);
      dev_busy = 1'b1;
      dev_left = int'(m_ar_len) + 1;
    end
    if (m_r_valid) begin
      check("s_r_valid", 64'(s_r_valid), 64'd1);
      check("s_r_data", 64'(s_r_data), 64'(m_r_data));
      check("s_r_resp", 64'(s_r_resp), 64'(m_r_resp));
      check("s_r_id", 64'(s_r_id), 64'(host_id));
      check("s_r_last", 64'(s_r_last), 64'(host_idx == host_n - 1));
      if (s_r_ready) begin
        if (s_r_last) last_count++;
        host_idx++;
        dev_left--;
        if (dev_left == 0) dev_busy = 1'b0;
        if (host_idx == host_n) begin
          txn_active = 1'b0;
          check("ar_leftover", 64'(exp_ar_q.size()), 64'd0);
        end
      end
    end else begin
      check("s_r_valid_quiet", 64'(s_r_valid), 64'd0);
    end
    if (s_ar_valid && s_ar_ready) begin
      e.addr = s_ar_addr; e.len = s_ar_len; e.id = s_ar_id;
      e.size = s_ar_size; e.burst = s_ar_burst;
      model_split(e);
      txn_active = 1'b1;
      host_n     = int'(s_ar_len) + 1;
      host_idx   = 0;
      host_id    = s_ar_id;
    end
  endtask

  // Device responder and host R backpressure, driven just after the rising edge.
  task automatic drive_cycle();
    if (rst_i) begin
      m_r_valid  = 1'b0;
      m_r_last   = 1'b0;
      m_ar_ready = 1'b0;
      return;
    end
    m_ar_ready = ($urandom_range(99) < arready_pct);
    case (ready_mode)
      0:       s_r_ready = 1'b1;
      1:       s_r_ready = !s_r_ready;
      default: s_r_ready = 1'($urandom_range(1));
    endcase
    if (m_r_valid && !mr_hs_last) begin
      // hold the current beat until it is taken
    end else if (dev_busy && dev_left > 0 && $urandom_range(9) < 8) begin
      m_r_valid = 1'b1;
      m_r_data  = $urandom;
      m_r_resp  = ($urandom_range(7) == 0) ? 2'd2 : 2'd0;
      m_r_last  = (dev_left == 1);
      m_r_id    = IW'($urandom);
    end else begin
      m_r_valid = 1'b0;
      m_r_last  = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) monitor_cycle();
      @(posedge clk_i);
      #1;
      drive_cycle();
    end
  end

  task automatic do_reset();
    rst_i      = 1'b1;
    s_ar_valid = 1'b0;
    flush_model();
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
  endtask

  task automatic start_ar(input logic [AW-1:0] addr, input int len, input int size,
                          input int burst, input int id);
    bit ok;
    ok = 1'b0;
    @(posedge clk_i);
    #1;
    s_ar_addr  = addr;
    s_ar_len   = 8'(len);
    s_ar_size  = 3'(size);
    s_ar_burst = 2'(burst);
    s_ar_id    = IW'(id);
    s_ar_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (s_ar_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk_i);
    #1 s_ar_valid = 1'b0;
    check("ar_accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk_i);
      if (!txn_active) begin
        ok = 1'b1;
        break;
      end
    end
    check("txn_done_timeout", 64'(ok), 64'd1);
    if (!ok) do_reset();
  endtask

  task automatic run_txn(input logic [AW-1:0] addr, input int len, input int size,
                         input int burst, input int id);
    ar_log.delete();
    last_count = 0;
    start_ar(addr, len, size, burst, id);
    wait_done();
  endtask

  initial begin
    logic [AW-1:0] t1_addr [4];
    logic [AW-1:0] a;
    int            len, size, burst, pick;
    bit            found;
    t1_addr = '{24'h000100, 24'h000140, 24'h000180, 24'h0001C0};
    n_vec = 0; n_err = 0;
    ready_mode = 0; arready_pct = 100;
    s_ar_valid = 1'b0; s_ar_addr = '0; s_ar_id = '0; s_ar_len = '0;
    s_ar_size = '0; s_ar_burst = '0; s_r_ready = 1'b1;
    m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_data = '0; m_r_id = '0;
    m_r_resp = '0; m_r_last = 1'b0;
    flush_model();
    rst_i = 1'b1;
    #1;
    check("rst_s_ar_ready", 64'(s_ar_ready), 64'd0);
    check("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
    check("rst_s_r_valid", 64'(s_r_valid), 64'd0);
    check("rst_m_r_ready", 64'(m_r_ready), 64'd0);
    check("rst_m_ar_addr", 64'(m_ar_addr), 64'd0);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1 check("post_rst_s_ar_ready", 64'(s_ar_ready), 64'd1);

    // 1: long INCR split into four 16-beat sub-bursts
    run_txn(24'h000100, 63, 2, 1, 0);
    check("t1_num_ar", 64'(ar_log.size()), 64'd4);
    if (ar_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t1_ar_addr", 64'(ar_log[i].addr), 64'(t1_addr[i]));
        check("t1_ar_len", 64'(ar_log[i].len), 64'd15);
      end
    end
    check("t1_beats", 64'(host_idx), 64'd64);
    check("t1_lasts", 64'(last_count), 64'd1);

    // 2: short INCR, single sub-burst, host ID returned
    run_txn(24'h000020, 3, 2, 1, 1);
    check("t2_num_ar", 64'(ar_log.size()), 64'd1);
    if (ar_log.size() == 1) begin
      check("t2_ar_addr", 64'(ar_log[0].addr), 64'h20);
      check("t2_ar_len", 64'(ar_log[0].len), 64'd3);
    end
    check("t2_lasts", 64'(last_count), 64'd1);

    // 3: WRAP forwarded unchanged
    run_txn(24'h00003C, 15, 2, 2, 0);
    check("t3_num_ar", 64'(ar_log.size()), 64'd1);
    if (ar_log.size() == 1) begin
      check("t3_ar_addr", 64'(ar_log[0].addr), 64'h3C);
      check("t3_ar_len", 64'(ar_log[0].len), 64'd15);
      check("t3_ar_burst", 64'(ar_log[0].burst), 64'd2);
    end
    check("t3_lasts", 64'(last_count), 64'd1);

    // 4: host ready toggling every cycle
    ready_mode = 1;
    run_txn(24'h001000, 31, 2, 1, 1);
    check("t4_beats", 64'(host_idx), 64'd32);
    check("t4_num_ar", 64'(ar_log.size()), 64'd2);
    ready_mode = 0;

    // 5: address wraps at the top of the space
    run_txn(24'hFFFFC0, 31, 2, 1, 0);
    check("t5_num_ar", 64'(ar_log.size()), 64'd2);
    if (ar_log.size() == 2) check("t5_ar1_addr", 64'(ar_log[1].addr), 64'h0);
    check("t5_beats", 64'(host_idx), 64'd32);

    // 6: reset during beat 10 of a 64-beat burst
    ar_log.delete();
    start_ar(24'h000400, 63, 2, 1, 1);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk_i);
      #2;
      if (host_idx == 9 && m_r_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reach_beat10", 64'(found), 64'd1);
    check("t6_pre_s_r_valid", 64'(s_r_valid), 64'd1);
    rst_i = 1'b1;
    #1;
    check("t6_s_r_valid", 64'(s_r_valid), 64'd0);
    check("t6_m_ar_valid", 64'(m_ar_valid), 64'd0);
    check("t6_s_ar_ready", 64'(s_ar_ready), 64'd0);
    flush_model();
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1 check("t6_post_s_ar_ready", 64'(s_ar_ready), 64'd1);
    run_txn(24'h000200, 5, 2, 1, 0);
    check("t6_next_beats", 64'(host_idx), 64'd6);
    check("t6_next_lasts", 64'(last_count), 64'd1);

    // Randomized bursts with random backpressure on every channel
    for (int t = 0; t < 40; t++) begin
      ready_mode  = $urandom_range(2);
      arready_pct = $urandom_range(30, 100);
      pick        = $urandom_range(9);
      size        = $urandom_range(2);
      a           = AW'($urandom);
      if (pick < 7) begin
        burst = 1;
        len   = ($urandom_range(3) == 0) ? $urandom_range(15) : $urandom_range(255);
      end else if (pick < 9) begin
        burst = 2;
        len   = (1 << $urandom_range(1, 4)) - 1;
        a     = a & ~AW'((1 << size) - 1);
      end else begin
        burst = 0;
        len   = $urandom_range(15);
      end
      run_txn(a, len, size, burst, $urandom_range(1));
      check("rnd_beats", 64'(host_idx), 64'(len + 1));
      check("rnd_lasts", 64'(last_count), 64'd1);
    end

    repeat (4) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
